mul_2x2_seq_ctrl: RTL

//  Digit-serial unsigned multiplier controller. Sequences one 2x2 multiplier

---
 rtl/sauria_mul_pkg.sv | 17 +
 rtl/mul_2x2.sv | 21 ++
 rtl/mul_2x2_seq_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sauria_mul_pkg.sv
// Shared types and helpers for the digit-serial multiplier controller.
//   mul_seq_state_t : controller FSM state encoding
//   digit_cnt_w()   : width of a 2-bit-digit counter for a w-bit operand
package sauria_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_seq_state_t;

    // A single-digit operand still gets a 1-bit counter so the port/regs exist.
    function automatic int digit_cnt_w(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

endpackage

// File: rtl/mul_2x2.sv
// 2x2 unsigned multiplier cell.
//   a_i, b_i : 2-bit unsigned digits
//   p_o      : 4-bit product
// APPROX=1 selects the underdesigned cell: 3x3 yields 7 instead of 9, so the
// product fits in 3 bits and never exceeds the exact value.
module mul_2x2 #(
    parameter int APPROX = 0
) (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    always_comb begin
        p_o = {2'b00, a_i} * {2'b00, b_i};
        if (APPROX != 0 && a_i == 2'b11 && b_i == 2'b11) begin
            p_o = 4'd7;
        end
    end

endmodule

// File: rtl/mul_2x2_seq_ctrl.sv
// Digit-serial unsigned multiplier controller. One 2x2 cell is stepped over
// every (A digit, B digit) pair; shifted partial products are accumulated
// into a full-width result. One operation in flight.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_valid/o_ready  : operand handshake (i_a, i_b unsigned)
//   o_valid/i_ready  : result handshake (o_ab)
//   o_busy           : high while an operation is running or being held
module mul_2x2_seq_ctrl
    import sauria_mul_pkg::*;
#(
    parameter int IA_W   = 8,
    parameter int IB_W   = 8,
    parameter int APPROX = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IA_W-1:0]      i_a,
    input  logic [IB_W-1:0]      i_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [IA_W+IB_W-1:0] o_ab,
    output logic                 o_busy
);

    localparam int NA   = IA_W / 2;
    localparam int NB   = IB_W / 2;
    localparam int AB_W = IA_W + IB_W;
    localparam int DA_W = digit_cnt_w(IA_W);
    localparam int DB_W = digit_cnt_w(IB_W);
    localparam int S_W  = ((DA_W > DB_W) ? DA_W : DB_W) + 1;

    localparam logic [DA_W-1:0] DA_LAST = DA_W'(NA - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(NB - 1);

    if ((IA_W % 2) != 0 || IA_W < 2 || (IB_W % 2) != 0 || IB_W < 2) begin : g_bad_width
        $error("mul_2x2_seq_ctrl: IA_W and IB_W must be even and >= 2");
    end

    mul_seq_state_t    state_q, state_d;
    logic [AB_W-1:0]   acc_q,   acc_d;
    logic [DA_W-1:0]   da_q,    da_d;
    logic [DB_W-1:0]   db_q,    db_d;
    logic [IA_W-1:0]   a_q,     a_d;
    logic [IB_W-1:0]   b_q,     b_d;

    logic [1:0]        a_dig, b_dig;
    logic [3:0]        cell_p;
    logic [S_W-1:0]    dsum;
    logic [S_W:0]      shamt;
    logic [AB_W-1:0]   pp;

    // Digit selects as constant-index muxes: no out-of-range part selects
    // when the digit count is not a power of two.
    always_comb begin
        a_dig = 2'b00;
        for (int i = 0; i < NA; i++) begin
            if (da_q == DA_W'(i)) a_dig = a_q[2*i +: 2];
        end
    end

    always_comb begin
        b_dig = 2'b00;
        for (int j = 0; j < NB; j++) begin
            if (db_q == DB_W'(j)) b_dig = b_q[2*j +: 2];
        end
    end

    mul_2x2 #(.APPROX(APPROX)) u_cell (
        .a_i (a_dig),
        .b_i (b_dig),
        .p_o (cell_p)
    );

    // Partial product weight is 4^(da+db).
    assign dsum  = S_W'(da_q) + S_W'(db_q);
    assign shamt = {dsum, 1'b0};
    assign pp    = AB_W'(cell_p) << shamt;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        da_d    = da_q;
        db_d    = db_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    acc_d   = '0;
                    da_d    = '0;
                    db_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + pp;
                if (da_q == DA_LAST) begin
                    da_d = '0;
                    if (db_q == DB_LAST) begin
                        state_d = DONE;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    da_d = da_q + 1'b1;
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            da_q    <= '0;
            db_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            da_q    <= da_d;
            db_q    <= db_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign o_ready = (state_q == IDLE) && !i_rst;
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q != IDLE);
    assign o_ab    = acc_q;

endmodule
